multicycle_unit_stall_ctrl: RTL
===============================

Name: multicycle_unit_stall_ctrl

Overview:
- Generalised stall/issue controller for NUM_UNITS multi-cycle execution units (FPU fast/slow, divider, etc.) that are dispatched from the exec stage.
- Per unit: generates a single-cycle start pulse and holds the pipeline until the unit returns valid. Latches the result so it stays stable under external stalls. Handles squash of in-flight operations.
- Sits beside the hazard unit; its stall_o/bubble_m_o are ORed into the stall_f/d/e and flush_m equations.

Parameters:
- NUM_UNITS, 2, number of independent multi-cycle units.
- DATA_W, 32, result width per unit.
- WDOG_W, 10, watchdog counter width (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- dispatch_e  in  NUM_UNITS  exec-stage instruction targets unit i; at most one bit set.
- hold_i  in  1  external global stall (cache stall); blocks issue and retire.
- squash_i  in  1  kill the exec-stage operation (branch redirect).
- unit_valid  in  NUM_UNITS  unit i result valid; may be a level or a 1-cycle pulse.
- unit_result  in  NUM_UNITS*DATA_W  unit i result, valid with unit_valid[i].
- unit_start  out  NUM_UNITS  1-cycle start pulse to unit i.
- stall_o  out  1  stall F/D/E.
- bubble_m_o  out  1  insert bubble into M (equals stall_o).
- result_o  out  DATA_W  result of the most recently completed operation, held.
- busy_o  out  NUM_UNITS  unit i not IDLE.
- err_multi_o  out  1  sticky; set when more than one dispatch_e bit is seen.
- wdog_o  out  NUM_UNITS  sticky watchdog flags (0 without the feature).

Behaviour:
- Reset: every FSM goes to IDLE. All outputs are 0; result_o is 0; counters are 0.
- Per-unit FSM states: IDLE, WAIT, HELD, DRAIN.
- IDLE:
  - If dispatch_e[i] & ~hold_i & ~squash_i, then unit_start[i]=1 in the same cycle (combinational) and go to WAIT.
  - If dispatch_e[i] & hold_i, no start and stay in IDLE.
- WAIT:
  - If squash_i, go to DRAIN. No retire. result_o is unchanged.
  - Else if unit_valid[i] & ~hold_i, latch unit_result[i] into result_o and go to IDLE. The instruction advances at this edge.
  - Else if unit_valid[i] & hold_i, latch the result and go to HELD.
- HELD: go to IDLE on ~hold_i. unit_valid is ignored in this state.
- DRAIN:
  - Waits for the orphaned result; unit_valid[i] moves to IDLE with no latch.
  - A new dispatch_e[i] arriving in DRAIN is stalled and is not started until the next cycle in IDLE.
- stall_o = OR over i of:
  - IDLE & dispatch_e[i] & ~hold_i & ~squash_i (issue cycle);
  - WAIT & ~unit_valid[i] & ~squash_i;
  - DRAIN & dispatch_e[i].
- stall_o is 0 in HELD (hold_i already freezes the pipe). stall_o is never asserted by squash.
- Back-to-back dispatch to the same unit: the retire edge lands the FSM in IDLE, so the next instruction starts one cycle later with a fresh pulse. Exactly one start is issued per instruction.
- Different units may be in WAIT simultaneously (after squash/drain). result_o is written by whichever unit retires. If two units retire in the same cycle, the lowest index wins.
- rst mid-operation returns to IDLE. A late unit_valid is then ignored because the FSM is not in WAIT.
- err_multi_o is cleared only by rst.

Optional Feature:
- Macro: MCU_WATCHDOG_EN.
- Defined:
  - Per-unit counter increments each WAIT/DRAIN cycle and clears on leaving those states.
  - At all-ones it sets wdog_o[i] (sticky) and forces the FSM to IDLE, releasing stall_o. result_o is set to all-ones.
- Undefined: no counters; wdog_o is tied to 0; the FSM waits indefinitely.

Test Plan:
- NUM_UNITS=2. dispatch_e=01; unit 0 valid arrives 4 cycles later with 0x3F800000 -> unit_start[0] high exactly 1 cycle. stall_o high for 4 cycles then low. result_o=0x3F800000. busy_o[0] clears at the retire edge.
- Two consecutive unit-1 instructions (dispatch_e held 10), unit latency 3 -> two separate unit_start[1] pulses. Total stall 3+3 cycles. Two distinct results appear in order.
- hold_i=1 at dispatch for 2 cycles -> no start until hold_i drops. hold_i rises the same cycle unit_valid arrives -> FSM enters HELD, result_o latched, stall_o=0; returns to IDLE when hold_i falls.
- squash_i in WAIT, then unit valid 5 cycles later with 0xDEAD -> result_o unchanged. A dispatch_e to the same unit during DRAIN stalls, then starts the cycle after the drain completes.
- dispatch_e=11 -> err_multi_o=1 and stays 1 until rst. rst asserted in WAIT -> busy_o=0, stall_o=0 the next cycle.
- With MCU_WATCHDOG_EN and WDOG_W=4, unit never valid -> after 15 WAIT cycles wdog_o[0]=1, stall_o=0, result_o=0xFFFFFFFF.

Source files
------------

// File: rtl/multicycle_unit_stall_ctrl.sv
// Issue/stall controller for NUM_UNITS multi-cycle execution units dispatched from E.
// Optional watchdog per unit enabled with `define MCU_WATCHDOG_EN.
module multicycle_unit_stall_ctrl #(
  parameter int unsigned NUM_UNITS = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned WDOG_W    = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_UNITS-1:0]        dispatch_e,
  input  logic                        hold_i,
  input  logic                        squash_i,
  input  logic [NUM_UNITS-1:0]        unit_valid,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_result,
  output logic [NUM_UNITS-1:0]        unit_start,
  output logic                        stall_o,
  output logic                        bubble_m_o,
  output logic [DATA_W-1:0]           result_o,
  output logic [NUM_UNITS-1:0]        busy_o,
  output logic                        err_multi_o,
  output logic [NUM_UNITS-1:0]        wdog_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HELD, S_DRAIN} state_e;

  state_e              state_q [NUM_UNITS];
  state_e              state_d [NUM_UNITS];
  logic [DATA_W-1:0]   result_q, result_d;
  logic                err_q, err_d;
  logic [NUM_UNITS-1:0] start_c;
  logic                stall_c;
  logic                ret_hit;
  logic                wd_fire;

`ifdef MCU_WATCHDOG_EN
  logic [WDOG_W-1:0]    cnt_q [NUM_UNITS];
  logic [WDOG_W-1:0]    cnt_d [NUM_UNITS];
  logic [NUM_UNITS-1:0] wdog_q, wdog_d;
`else
  localparam int unsigned WdogWUnused = WDOG_W;
`endif

  always_comb begin
    start_c  = '0;
    stall_c  = 1'b0;
    ret_hit  = 1'b0;
    wd_fire  = 1'b0;
    result_d = result_q;
    err_d    = err_q | ($countones(dispatch_e) > 1);
`ifdef MCU_WATCHDOG_EN
    wdog_d   = wdog_q;
`endif
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        S_IDLE: begin
          if (dispatch_e[i] && !hold_i && !squash_i) begin
            start_c[i] = 1'b1;
            stall_c    = 1'b1;
            state_d[i] = S_WAIT;
          end
        end
        S_WAIT: begin
          if (squash_i) begin
            state_d[i] = S_DRAIN;
          end else if (unit_valid[i]) begin
            // Ascending scan: the lowest-index retiring unit owns result_o.
            if (!ret_hit) begin
              result_d = unit_result[i*DATA_W +: DATA_W];
              ret_hit  = 1'b1;
            end
            state_d[i] = hold_i ? S_HELD : S_IDLE;
          end else begin
            stall_c = 1'b1;
`ifdef MCU_WATCHDOG_EN
            if (cnt_q[i] == '1) begin
              stall_c    = 1'b0;
              wd_fire    = 1'b1;
              wdog_d[i]  = 1'b1;
              state_d[i] = S_IDLE;
            end
`endif
          end
        end
        S_HELD: begin
          if (!hold_i) state_d[i] = S_IDLE;
        end
        S_DRAIN: begin
          if (dispatch_e[i]) stall_c = 1'b1;
          if (unit_valid[i]) begin
            state_d[i] = S_IDLE;
          end
`ifdef MCU_WATCHDOG_EN
          else if (cnt_q[i] == '1) begin
            wd_fire    = 1'b1;
            wdog_d[i]  = 1'b1;
            state_d[i] = S_IDLE;
          end
`endif
        end
        default: state_d[i] = S_IDLE;
      endcase
`ifdef MCU_WATCHDOG_EN
      if ((state_q[i] == S_WAIT || state_q[i] == S_DRAIN) &&
          (state_d[i] == S_WAIT || state_d[i] == S_DRAIN))
        cnt_d[i] = cnt_q[i] + 1'b1;
      else
        cnt_d[i] = '0;
`endif
    end
    if (wd_fire && !ret_hit) result_d = '1;
    if (rst) begin
      start_c = '0;
      stall_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) state_q[i] <= S_IDLE;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) state_q[i] <= state_d[i];
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

`ifdef MCU_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) cnt_q[i] <= '0;
      wdog_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) cnt_q[i] <= cnt_d[i];
      wdog_q <= wdog_d;
    end
  end
  assign wdog_o = wdog_q;
`else
  assign wdog_o = '0;
`endif

  always_comb begin
    busy_o = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) busy_o[i] = (state_q[i] != S_IDLE);
  end

  assign unit_start  = start_c;
  assign stall_o     = stall_c;
  assign bubble_m_o  = stall_c;
  assign result_o    = result_q;
  assign err_multi_o = err_q;

endmodule
